seq_multiplier: RTL and testbench

- Iterative unsigned shift-add multiplier for the integer execute path; consumes the recursive `simple_adder` (one `bits`-wide instance, no second adder).
- Produces a full `2*bits` product in a fixed `bits` cycles, one add-and-shift step per cycle.
- Valid/ready handshake on both the operand side and the result side, so the ALU/writeback logic can stall it.

---
 rtl/seq_multiplier.sv | 132 +++++++++++++
 tb/tb_seq_multiplier.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative unsigned shift-add multiplier built on a recursive halving adder
// One bits-wide add per cycle; full 2*bits product after exactly bits steps.

module simple_adder #(
    parameter int bits = 32
) (
    input  logic [bits-1:0] a,
    input  logic [bits-1:0] b,
    input  logic            cin,
    output logic [bits-1:0] sum,
    output logic            cout
);
    if (bits == 1) begin : g_leaf
        assign sum  = a ^ b ^ cin;
        assign cout = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
    end else begin : g_split
        localparam int lo_bits = bits / 2;
        localparam int hi_bits = bits - lo_bits;
        logic c_mid;

        simple_adder #(.bits(lo_bits)) u_lo (
            .a    (a[lo_bits-1:0]),
            .b    (b[lo_bits-1:0]),
            .cin  (cin),
            .sum  (sum[lo_bits-1:0]),
            .cout (c_mid)
        );

        simple_adder #(.bits(hi_bits)) u_hi (
            .a    (a[bits-1:lo_bits]),
            .b    (b[bits-1:lo_bits]),
            .cin  (c_mid),
            .sum  (sum[bits-1:lo_bits]),
            .cout (cout)
        );
    end
endmodule

module seq_multiplier #(
    parameter int bits = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [bits-1:0]   a,
    input  logic [bits-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*bits-1:0] product
);
    localparam int cw = $clog2(bits) + 1;
    localparam logic [cw-1:0] last_step = cw'(bits - 1);

    if (bits < 2 || (bits & (bits - 1)) != 0) begin : g_bad_bits
        $error("seq_multiplier: bits must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [bits-1:0] mcand;
    logic [bits-1:0] acc_hi;
    logic [bits-1:0] acc_lo;
    logic [cw-1:0]   count;

    logic [bits-1:0] addend;
    logic [bits-1:0] sum;
    logic            cout;

    assign addend = acc_lo[0] ? mcand : '0;

    simple_adder #(.bits(bits)) u_adder (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // acc_lo starts as the multiplier and is consumed LSB-first as product bits shift in
    assign product = {acc_hi, acc_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= a;
                        acc_lo   <= b;
                        acc_hi   <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    {acc_hi, acc_lo} <= {cout, sum, acc_lo[bits-1:1]};
                    count            <= count + cw'(1);
                    if (count == last_step) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed and randomized checks of seq_multiplier at bits=32 and bits=8

module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        iv32 = 1'b0, or32 = 1'b1;
    logic        ir32, ov32;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] p32;

    logic        iv8 = 1'b0, or8 = 1'b1;
    logic        ir8, ov8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.bits(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .out_valid(ov32), .out_ready(or32), .product(p32)
    );

    seq_multiplier #(.bits(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .product(p8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic vld(input bit w8);
        return w8 ? ov8 : ov32;
    endfunction

    function automatic logic rdy(input bit w8);
        return w8 ? ir8 : ir32;
    endfunction

    function automatic logic [63:0] prod(input bit w8);
        return w8 ? {48'd0, p8} : p32;
    endfunction

    task automatic drive(input bit w8, input logic iv, input logic [31:0] x, input logic [31:0] y);
        if (w8) begin
            iv8 = iv; a8 = x[7:0]; b8 = y[7:0];
        end else begin
            iv32 = iv; a32 = x; b32 = y;
        end
    endtask

    task automatic set_ready(input bit w8, input logic r);
        if (w8) or8 = r;
        else or32 = r;
    endtask

    // junk keeps in_valid high with other operands while busy to show they are ignored
    task automatic do_op(input bit w8, input logic [31:0] x, input logic [31:0] y,
                         input int stall, input bit junk, input string tag);
        int n;
        int width;
        logic [63:0] exp;
        width = w8 ? 8 : 32;
        exp = w8 ? 64'(x[7:0]) * 64'(y[7:0]) : 64'(x) * 64'(y);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(rdy(w8)), 64'd1);
        set_ready(w8, stall == 0);
        drive(w8, 1'b1, x, y);
        @(negedge clk);
        if (junk) drive(w8, 1'b1, ~x, ~y);
        else drive(w8, 1'b0, '0, '0);
        n = 0;
        while (!vld(w8) && n < 100) begin
            if (junk && n == 5) check({tag, "_busy_not_ready"}, 64'(rdy(w8)), 64'd0);
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(width));
        check({tag, "_product"}, prod(w8), exp);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check({tag, "_held_valid"}, 64'(vld(w8)), 64'd1);
            check({tag, "_held_product"}, prod(w8), exp);
            if (junk) check({tag, "_done_not_ready"}, 64'(rdy(w8)), 64'd0);
            set_ready(w8, 1'b1);
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        drive(w8, 1'b0, '0, '0);
        check({tag, "_pulse_end"}, 64'(vld(w8)), 64'd0);
        check({tag, "_idle_ready"}, 64'(rdy(w8)), 64'd1);
        check({tag, "_idle_product"}, prod(w8), exp);
    endtask

    initial begin
        int seen;
        // asynchronous reset in the middle of a cycle, before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", 64'(ir32), 64'd1);
        check("rst_out_valid", 64'(ov32), 64'd0);
        check("rst_product", p32, 64'd0);
        check("rst8_product", {48'd0, p8}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op(1'b0, 32'd7, 32'd6, 0, 1'b0, "basic");
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "max32");
        do_op(1'b1, 32'hFF, 32'hFF, 0, 1'b0, "max8");
        do_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5, 1'b1, "bp");
        do_op(1'b0, 32'd0, 32'hDEAD_BEEF, 0, 1'b0, "zero");
        do_op(1'b1, 32'h80, 32'h02, 2, 1'b1, "bp8");

        // reset mid-operation discards the in-flight result
        @(negedge clk);
        drive(1'b0, 1'b1, 32'd3, 32'd5);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", 64'(ir32), 64'd1);
        check("midrst_product", p32, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov32) seen++;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        do_op(1'b0, 32'd3, 32'd5, 0, 1'b0, "after_rst");

        for (int i = 0; i < 150; i++)
            do_op(1'b0, $urandom, $urandom, $urandom_range(0, 3), 1'b0, "rnd32");
        for (int i = 0; i < 150; i++)
            do_op(1'b1, $urandom, $urandom, $urandom_range(0, 3), 1'b0, "rnd8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
